bnn_layer_seq: RTL and testbench
================================

# bnn_layer_seq

Parametrised binary-neural-network layer that evaluates N_NEURONS XNOR-popcount neurons over an N_IN-bit binary input vector, one neuron per clock, behind valid/ready handshakes. Weights and per-neuron thresholds are runtime-writable through an addressed config port, with no fixed neuron slot counter. It sits between the input pin-capture logic and the output pin mux, and replaces the fixed 6-input, 4-neuron combinational layer.

## Interface

Parameters:
- N_IN, 8: input vector width, equal to the weight width per neuron (≥2).
- N_NEURONS, 4: neuron count (≥2).
- CNT_W, $clog2(N_IN+1): popcount and threshold width.
- AW, $clog2(N_NEURONS): config address width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  config write strobe.
- cfg_thr  in  1  write target: 1 = threshold, 0 = weight.
- cfg_addr  in  AW  neuron index.
- cfg_data  in  N_IN  weight bits; threshold writes use cfg_data[CNT_W-1:0].
- cfg_ready  out  1  high when a config write would be accepted (state IDLE).
- in_valid  in  1  input vector valid.
- in_data  in  N_IN  binary input vector.
- in_ready  out  1  high in IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  N_NEURONS  neuron k result on bit k.
- busy  out  1  high in EVAL or DONE.

## Operation

Reset values:
- All weights are 0. All thresholds are N_IN/2 (integer division).
- State is IDLE and the neuron index is 0.
- out_data = 0, out_valid = 0, busy = 0, in_ready = 1, cfg_ready = 1.

Config:
- A write occurs on a clock edge where cfg_we && cfg_ready.
- The write updates weight[cfg_addr] or threshold[cfg_addr], selected by cfg_thr.
- A write with cfg_addr ≥ N_NEURONS is discarded.
- A write with cfg_we high outside IDLE is discarded, with no queuing.

Neuron function:
- pop_k = popcount(in_reg XNOR weight[k]), range 0..N_IN, held in CNT_W bits.
- bit_k = (pop_k ≥ threshold[k]), unsigned compare.
- Threshold 0 always gives 1. A threshold greater than N_IN always gives 0.

State machine:
- IDLE: on in_valid, latch in_data into in_reg, clear the index and the out_data shadow, then go to EVAL.
- EVAL: each cycle compute bit_k for index k and store it. At k = N_NEURONS-1, copy the shadow to out_data and go to DONE. Otherwise increment k.
- DONE: out_valid = 1 and out_data is held stable. On out_ready, go to IDLE.
- out_data keeps its last result after the handshake completes, until the next DONE.

Simultaneous events:
- A config write and an input acceptance on the same IDLE edge are both performed.
- EVAL reads the registers on later cycles, so the evaluation uses the new configuration.

## Timing

- Acceptance occurs on edge T (in_valid && in_ready).
- EVAL occupies the cycles after edges T..T+N_NEURONS-1.
- out_valid rises after edge T+N_NEURONS, so latency is N_NEURONS cycles.
- If out_ready is already high, the handshake completes at edge T+N_NEURONS+1. IDLE follows, and in_ready is high from then.
- Maximum throughput is one vector per N_NEURONS+2 cycles.
- in_ready, cfg_ready and busy are decoded from state registers only, with no combinational path from the inputs.
- out_valid and out_data are registered.
- Asserting reset in any state returns all state to the reset values immediately, including the configuration registers.
- Any result in flight is dropped, and out_valid falls without a handshake.

## Test plan

All scenarios use N_IN=8, N_NEURONS=4.

1. After reset:
   - in_data=0xFF gives popcount 0 < 4, so out_data=4'b0000.
   - in_data=0x00 gives popcount 8, so out_data=4'b1111.
2. Write weights w0=0xF0, w1=0x0F, w2=0xFF, w3=0xAA, then apply in_data=0xF0. Popcounts are 8, 0, 4, 4, so out_data=4'b1101.
3. With scenario 2 weights, set threshold0=0 and threshold1=9.
   - Bit 0 is 1 for in_data=0x0F.
   - Bit 1 is 0 for in_data=0x0F, even though pop1=8.
4. Latency and handshake, with out_ready held high:
   - Accept at edge T; out_valid is 1 exactly after edge T+4.
   - in_ready is 0 during T+1..T+5 and returns to 1 after T+5.
5. Backpressure and config lockout:
   - Hold out_ready=0 for 6 cycles in DONE. out_valid and out_data stay stable and in_ready stays 0.
   - A cfg_we to w0 issued during EVAL is discarded. The next vector's bit 0 matches the old w0.
   - A write to cfg_addr 4 or above has no effect. With N_NEURONS=4 (AW=2) such an address cannot be driven; run this check on a configuration with a non-power-of-two N_NEURONS such as 5 (AW=3).
6. Assert reset two cycles into EVAL:
   - out_valid=0, busy=0 and in_ready=1 immediately.
   - The weights revert to 0, so the scenario-1 response reappears.

Source files
------------

// File: rtl/bnn_layer_seq_if.sv
// Handshake and config bundle between the pin-capture logic, the BNN layer and the output mux.
interface bnn_layer_seq_if #(
   parameter int unsigned N_IN      = 8,
   parameter int unsigned N_NEURONS = 4,
   parameter int unsigned CNT_W     = $clog2(N_IN + 1),
   parameter int unsigned AW        = $clog2(N_NEURONS)
);
   logic                 cfg_we;
   logic                 cfg_thr;
   logic [AW-1:0]        cfg_addr;
   logic [N_IN-1:0]      cfg_data;
   logic                 cfg_ready;
   logic                 in_valid;
   logic [N_IN-1:0]      in_data;
   logic                 in_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [N_NEURONS-1:0] out_data;
   logic                 busy;

   // Upstream/downstream driver side
   modport master (
      output cfg_we, cfg_thr, cfg_addr, cfg_data, in_valid, in_data, out_ready,
      input  cfg_ready, in_ready, out_valid, out_data, busy
   );

   // Layer side
   modport slave (
      input  cfg_we, cfg_thr, cfg_addr, cfg_data, in_valid, in_data, out_ready,
      output cfg_ready, in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/bnn_layer_seq.sv
// Sequential XNOR-popcount BNN layer: one neuron per clock, runtime-writable weights/thresholds.
module bnn_layer_seq #(
   parameter int unsigned N_IN      = 8,
   parameter int unsigned N_NEURONS = 4,
   parameter int unsigned CNT_W     = $clog2(N_IN + 1),
   parameter int unsigned AW        = $clog2(N_NEURONS)
) (
   input  logic          clk,
   input  logic          reset,
   bnn_layer_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   localparam logic [AW-1:0]    LAST_IDX = AW'(N_NEURONS - 1);
   localparam logic [CNT_W-1:0] THR_RST  = CNT_W'(N_IN / 2);

   state_t               state_q, state_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic [N_IN-1:0]      in_reg_q, in_reg_d;
   logic [N_NEURONS-1:0] shadow_q, shadow_d;
   logic [N_NEURONS-1:0] out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 idle_q, idle_d;
   logic                 busy_q, busy_d;
   logic [N_IN-1:0]      weight_q [N_NEURONS];
   logic [N_IN-1:0]      weight_d [N_NEURONS];
   logic [CNT_W-1:0]     thr_q    [N_NEURONS];
   logic [CNT_W-1:0]     thr_d    [N_NEURONS];

   logic [N_IN-1:0]      match_c;
   logic [CNT_W-1:0]     pop_c;
   logic                 bit_c;

   // Evaluate the neuron selected by the current index
   always_comb begin
      match_c = ~(in_reg_q ^ weight_q[idx_q]);
      pop_c   = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         pop_c = pop_c + CNT_W'(match_c[i]);
      end
      bit_c = (pop_c >= thr_q[idx_q]);
   end

   // Next-state, config update and registered-output decode
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      in_reg_d   = in_reg_q;
      shadow_d   = shadow_q;
      out_data_d = out_data_q;
      weight_d   = weight_q;
      thr_d      = thr_q;

      // Config writes only land in IDLE; out-of-range addresses match no slot
      if (bus.cfg_we && idle_q) begin
         for (int k = 0; k < int'(N_NEURONS); k++) begin
            if (bus.cfg_addr == AW'(k)) begin
               if (bus.cfg_thr) thr_d[k]    = bus.cfg_data[CNT_W-1:0];
               else             weight_d[k] = bus.cfg_data;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               in_reg_d = bus.in_data;
               idx_d    = '0;
               shadow_d = '0;
               state_d  = EVAL;
            end
         end
         EVAL: begin
            for (int k = 0; k < int'(N_NEURONS); k++) begin
               if (idx_q == AW'(k)) shadow_d[k] = bit_c;
            end
            if (idx_q == LAST_IDX) begin
               out_data_d = shadow_d;
               state_d    = DONE;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DONE);
      idle_d      = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State, configuration and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         in_reg_q    <= '0;
         shadow_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         idle_q      <= 1'b1;
         busy_q      <= 1'b0;
         for (int k = 0; k < int'(N_NEURONS); k++) begin
            weight_q[k] <= '0;
            thr_q[k]    <= THR_RST;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         in_reg_q    <= in_reg_d;
         shadow_q    <= shadow_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         idle_q      <= idle_d;
         busy_q      <= busy_d;
         weight_q    <= weight_d;
         thr_q       <= thr_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = idle_q;
   assign bus.cfg_ready = idle_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bnn_layer_seq.sv
// Scoreboard bench for bnn_layer_seq: a 4-neuron instance for function/timing and a 5-neuron one for address range.
module tb_bnn_layer_seq;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [3:0] exp_q  [$];
   logic [4:0] exp5_q [$];

   always #5 clk = ~clk;

   bnn_layer_seq_if #(.N_IN(8), .N_NEURONS(4)) b4 ();
   bnn_layer_seq_if #(.N_IN(8), .N_NEURONS(5)) b5 ();

   bnn_layer_seq #(.N_IN(8), .N_NEURONS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));
   bnn_layer_seq #(.N_IN(8), .N_NEURONS(5)) u_dut5 (.clk(clk), .reset(reset), .bus(b5));

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Output monitor for the 4-neuron instance
   always @(negedge clk) begin
      if (!reset && b4.out_valid && b4.out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out4_unexpected: got %0h want none", b4.out_data);
         end else begin
            chk("out4_data", int'(b4.out_data), int'(exp_q.pop_front()));
         end
      end
   end

   // Output monitor for the 5-neuron instance
   always @(negedge clk) begin
      if (!reset && b5.out_valid && b5.out_ready) begin
         if (exp5_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out5_unexpected: got %0h want none", b5.out_data);
         end else begin
            chk("out5_data", int'(b5.out_data), int'(exp5_q.pop_front()));
         end
      end
   end

   task automatic wait_ready4();
      int n = 0;
      while (!b4.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_in_ready4", int'(b4.in_ready), 1);
   endtask

   task automatic send4(input logic [7:0] d, input logic [3:0] e);
      wait_ready4();
      b4.in_valid = 1'b1;
      b4.in_data  = d;
      exp_q.push_back(e);
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
   endtask

   task automatic cfg4(input logic thr, input logic [1:0] a, input logic [7:0] d);
      wait_ready4();
      b4.cfg_we   = 1'b1;
      b4.cfg_thr  = thr;
      b4.cfg_addr = a;
      b4.cfg_data = d;
      @(posedge clk); #1;
      b4.cfg_we   = 1'b0;
   endtask

   task automatic cfg5(input logic thr, input logic [2:0] a, input logic [7:0] d);
      b5.cfg_we   = 1'b1;
      b5.cfg_thr  = thr;
      b5.cfg_addr = a;
      b5.cfg_data = d;
      @(posedge clk); #1;
      b5.cfg_we   = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      b4.cfg_we = 1'b0; b4.cfg_thr = 1'b0; b4.cfg_addr = '0; b4.cfg_data = '0;
      b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1;
      b5.cfg_we = 1'b0; b5.cfg_thr = 1'b0; b5.cfg_addr = '0; b5.cfg_data = '0;
      b5.in_valid = 1'b0; b5.in_data = '0; b5.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_out_data",  int'(b4.out_data),  0);
      chk("rst_out_valid", int'(b4.out_valid), 0);
      chk("rst_busy",      int'(b4.busy),      0);
      chk("rst_in_ready",  int'(b4.in_ready),  1);
      chk("rst_cfg_ready", int'(b4.cfg_ready), 1);

      // Default weights 0, thresholds 4
      send4(8'hFF, 4'h0);
      send4(8'h00, 4'hF);

      // Loaded weights: popcounts 8,0,4,4
      cfg4(1'b0, 2'd0, 8'hF0);
      cfg4(1'b0, 2'd1, 8'h0F);
      cfg4(1'b0, 2'd2, 8'hFF);
      cfg4(1'b0, 2'd3, 8'hAA);
      send4(8'hF0, 4'hD);

      // Threshold extremes: 0 always fires, 9 never does
      cfg4(1'b1, 2'd0, 8'h00);
      cfg4(1'b1, 2'd1, 8'h09);
      send4(8'h0F, 4'hD);

      // Latency and handshake with out_ready held high
      wait_ready4();
      b4.in_valid = 1'b1;
      b4.in_data  = 8'h00;
      exp_q.push_back(4'h9);
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      for (int s = 0; s < 6; s++) begin
         if (s > 0) begin
            @(posedge clk); #1;
         end
         chk($sformatf("lat_out_valid_%0d", s), int'(b4.out_valid), int'(s == 4));
         chk($sformatf("lat_in_ready_%0d", s),  int'(b4.in_ready),  int'(s == 5));
      end

      // Backpressure, with a config write attempted during EVAL
      cfg4(1'b1, 2'd0, 8'h04);
      b4.out_ready = 1'b0;
      send4(8'hFF, 4'hD);
      b4.cfg_we   = 1'b1;
      b4.cfg_thr  = 1'b0;
      b4.cfg_addr = 2'd0;
      b4.cfg_data = 8'h00;
      @(posedge clk); #1;
      b4.cfg_we   = 1'b0;
      n = 0;
      while (!b4.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_out_valid_rise", int'(b4.out_valid), 1);
      for (int s = 0; s < 6; s++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_out_valid_%0d", s), int'(b4.out_valid), 1);
         chk($sformatf("bp_out_data_%0d", s),  int'(b4.out_data),  4'hD);
         chk($sformatf("bp_in_ready_%0d", s),  int'(b4.in_ready),  0);
      end
      b4.out_ready = 1'b1;
      // Old w0=F0 kept: bit0 = 0
      send4(8'h0F, 4'hC);

      // Reset two cycles into EVAL drops the result and the configuration
      wait_ready4();
      b4.in_valid = 1'b1;
      b4.in_data  = 8'hF0;
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", int'(b4.out_valid), 0);
      chk("mid_rst_busy",      int'(b4.busy),      0);
      chk("mid_rst_in_ready",  int'(b4.in_ready),  1);
      chk("mid_rst_out_data",  int'(b4.out_data),  0);
      @(posedge clk); #1;
      reset = 1'b0;
      send4(8'hFF, 4'h0);
      send4(8'h00, 4'hF);

      // 5-neuron instance: addresses 5..7 discarded, address 4 accepted
      cfg5(1'b0, 3'd5, 8'hFF);
      cfg5(1'b0, 3'd6, 8'hFF);
      cfg5(1'b0, 3'd7, 8'hFF);
      cfg5(1'b1, 3'd5, 8'h00);
      cfg5(1'b1, 3'd7, 8'h00);
      cfg5(1'b0, 3'd4, 8'hFF);
      chk("n5_in_ready", int'(b5.in_ready), 1);
      b5.in_valid = 1'b1;
      b5.in_data  = 8'hFF;
      exp5_q.push_back(5'h10);
      @(posedge clk); #1;
      b5.in_valid = 1'b0;

      n = 0;
      while ((exp_q.size() != 0 || exp5_q.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain4", exp_q.size(),  0);
      chk("drain5", exp5_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
